// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: widths, ALU opcodes and flag bit positions.
// Build option: define EXE_SAT_EN to make add/sub saturate on signed overflow.
package exe_pkg;

   localparam int DW   = 6;           // data width, signed two's complement
   localparam int RW   = 4;           // register index width
   localparam int NREG = 2 ** RW;     // architectural registers, R0 included
   localparam int FW   = 4;           // flag vector width {Z,N,C,V}

   // ALU opcodes, taken directly from the instruction word
   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_SHF = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_OR  = 3'b100;
   localparam logic [2:0] OP_XOR = 3'b101;
   localparam logic [2:0] OP_NOT = 3'b110;
   localparam logic [2:0] OP_MOV = 3'b111;

   // Flag bit indices inside o_flag
   localparam int FLG_V = 0;
   localparam int FLG_C = 1;
   localparam int FLG_N = 2;
   localparam int FLG_Z = 3;

   // Saturation limits for signed add/sub
   localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
   localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

endpackage

// File: rtl/exe_alu.sv
// Purely combinational ALU: (a, b, op) -> (res, {Z,N,C,V}).
// Build option: EXE_SAT_EN makes add/sub clamp to SAT_MAX/SAT_MIN on signed overflow.
module exe_alu
   import exe_pkg::*;
(
   input  logic [DW-1:0] i_a,
   input  logic [DW-1:0] i_b,
   input  logic [2:0]    i_op,
   output logic [DW-1:0] o_res,
   output logic [FW-1:0] o_flags
);

   logic [DW:0]        w_sum;      // extra MSB is the carry-out
   logic [DW:0]        w_dif;      // extra MSB is the borrow (a < b unsigned)
   logic               w_add_ovf;
   logic               w_sub_ovf;
   logic [DW:0]        w_shl;      // bit DW holds the last bit shifted out
   logic signed [DW:0] w_shr;      // bit 0 holds the last bit shifted out
   logic [DW:0]        w_mag;      // |B| for negative B, range 1..2**(DW-1)
   logic [DW-1:0]      w_res;
   logic               w_c;
   logic               w_v;

   assign w_sum     = {1'b0, i_a} + {1'b0, i_b};
   assign w_dif     = {1'b0, i_a} - {1'b0, i_b};
   assign w_add_ovf = (i_a[DW-1] == i_b[DW-1]) && (w_sum[DW-1] != i_a[DW-1]);
   assign w_sub_ovf = (i_a[DW-1] != i_b[DW-1]) && (w_dif[DW-1] != i_a[DW-1]);

   // One guard bit on each side of A captures the carry from the shift; counts past
   // the width shift zeros (left) or the sign (right) through the guard bit.
   assign w_mag = -{i_b[DW-1], i_b};
   assign w_shl = {1'b0, i_a} << i_b;
   assign w_shr = $signed({i_a, 1'b0}) >>> w_mag;

   // Operation select with carry/overflow generation; defaults pass A through.
   always_comb begin
      w_res = i_a;
      w_c   = 1'b0;
      w_v   = 1'b0;
      case (i_op)
         OP_ADD: begin
            w_res = w_sum[DW-1:0];
            w_c   = w_sum[DW];
            w_v   = w_add_ovf;
`ifdef EXE_SAT_EN
            if (w_add_ovf) w_res = i_a[DW-1] ? SAT_MIN : SAT_MAX;
`endif
         end
         OP_SUB: begin
            w_res = w_dif[DW-1:0];
            w_c   = w_dif[DW];
            w_v   = w_sub_ovf;
`ifdef EXE_SAT_EN
            if (w_sub_ovf) w_res = i_a[DW-1] ? SAT_MIN : SAT_MAX;
`endif
         end
         OP_SHF: begin
            if (i_b[DW-1]) begin
               w_res = w_shr[DW:1];
               w_c   = w_shr[0];
            end else if (i_b != '0) begin
               w_res = w_shl[DW-1:0];
               w_c   = w_shl[DW];
            end
         end
         OP_AND:  w_res = i_a & i_b;
         OP_OR:   w_res = i_a | i_b;
         OP_XOR:  w_res = i_a ^ i_b;
         OP_NOT:  w_res = ~i_a;
         OP_MOV:  w_res = i_a;
         default: w_res = i_a;
      endcase
   end

   assign o_res = w_res;
   assign o_flags[FLG_Z] = (w_res == '0);
   assign o_flags[FLG_N] = w_res[DW-1];
   assign o_flags[FLG_C] = w_c;
   assign o_flags[FLG_V] = w_v;

endmodule

// File: rtl/exe_unit.sv
// Execute stage top: R1..R15 register file, immediate/ALU result mux and output registers.
// R0 has no storage; reading it returns the external operand i_data2.
// Build option: EXE_SAT_EN (passed through to exe_alu) enables add/sub saturation.
module exe_unit
   import exe_pkg::*;
(
   input  logic          i_clk,
   input  logic          i_rsn,
   input  logic [2:0]    i_oper,
   input  logic [RW-1:0] i_reg0,
   input  logic [RW-1:0] i_reg1,
   input  logic [RW-1:0] i_reg2,
   input  logic [DW-1:0] i_data,
   input  logic          i_imm,
   input  logic [DW-1:0] i_data2,
   output logic [DW-1:0] o_data,
   output logic [FW-1:0] o_flag
);

   logic [DW-1:0] w_rf [0:NREG-1];   // read view: index 0 is the external operand
   logic [DW-1:0] w_a;
   logic [DW-1:0] w_b;
   logic [DW-1:0] w_alu_res;
   logic [FW-1:0] w_alu_flags;
   logic [DW-1:0] w_res;
   logic [FW-1:0] w_flags;

   assign w_rf[0] = i_data2;

   genvar gi;
   generate
      for (gi = 1; gi < NREG; gi++) begin : g_reg
         logic [DW-1:0] r_q;

         // Register gi: cleared by reset, otherwise loaded when it is the destination.
         always_ff @(posedge i_clk) begin
            if (i_rsn)
               r_q <= '0;
            else if (i_reg2 == RW'(gi))
               r_q <= w_res;
         end

         assign w_rf[gi] = r_q;
      end
   endgenerate

   // Asynchronous reads see the pre-edge contents, so same-cycle writes are not bypassed.
   assign w_a = w_rf[i_reg0];
   assign w_b = w_rf[i_reg1];

   exe_alu u_alu (
      .i_a     (w_a),
      .i_b     (w_b),
      .i_op    (i_oper),
      .o_res   (w_alu_res),
      .o_flags (w_alu_flags)
   );

   // Immediate loads bypass the ALU; only Z and N are meaningful for them.
   always_comb begin
      w_res   = w_alu_res;
      w_flags = w_alu_flags;
      if (i_imm) begin
         w_res          = i_data;
         w_flags        = '0;
         w_flags[FLG_Z] = (i_data == '0);
         w_flags[FLG_N] = i_data[DW-1];
      end
   end

   // Registered result and flags, one cycle after the operands are presented.
   always_ff @(posedge i_clk) begin
      if (i_rsn) begin
         o_data <= '0;
         o_flag <= '0;
      end else begin
         o_data <= w_res;
         o_flag <= w_flags;
      end
   end

endmodule

// File: tb/tb_exe_unit.sv
// Self-checking bench for exe_unit: directed sequence, R0 handling, reset priority
// and randomized operations checked against an integer-arithmetic reference model.
module tb_exe_unit;

   logic       clk = 1'b0;
   logic       rsn;
   logic [2:0] oper;
   logic [3:0] reg0, reg1, reg2;
   logic [5:0] data, data2;
   logic       imm;
   logic [5:0] o_data;
   logic [3:0] o_flag;

   int n_vec  = 0;
   int n_miss = 0;

   // Reference state: architectural registers held as signed integers
   int         m_regs [16];
   logic [5:0] exp_data;
   logic [3:0] exp_flag;

   typedef struct {
      bit         im;
      logic [2:0] op;
      logic [3:0] ra;
      logic [3:0] rb;
      logic [3:0] rd;
      logic [5:0] d;
      logic [5:0] ed;
      logic [3:0] ef;
   } step_t;

   exe_unit dut (
      .i_clk   (clk),
      .i_rsn   (rsn),
      .i_oper  (oper),
      .i_reg0  (reg0),
      .i_reg1  (reg1),
      .i_reg2  (reg2),
      .i_data  (data),
      .i_imm   (imm),
      .i_data2 (data2),
      .o_data  (o_data),
      .o_flag  (o_flag)
   );

   always #5 clk = ~clk;

   function automatic int sx(input logic [5:0] v);
      return v[5] ? int'(v) - 64 : int'(v);
   endfunction

   function automatic int wrap6(input int x);
      int y;
      y = x & 63;
      return (y >= 32) ? y - 64 : y;
   endfunction

   // Reference model: plain integer arithmetic, shifts done one bit at a time.
   task automatic model(input bit r, input bit im, input logic [2:0] op,
                        input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rd,
                        input logic [5:0] d, input logic [5:0] d2);
      int a, b, raw, res, u, ua, ub;
      bit c, v;
      a  = (ra == 0) ? sx(d2) : m_regs[ra];
      b  = (rb == 0) ? sx(d2) : m_regs[rb];
      ua = a & 63;
      ub = b & 63;
      c  = 0;
      v  = 0;
      res = a;
      if (im) begin
         res = sx(d);
      end else begin
         case (op)
            3'd0: begin
               raw = a + b;
               c   = (ua + ub) > 63;
               v   = (raw > 31) || (raw < -32);
               res = wrap6(raw);
`ifdef EXE_SAT_EN
               if (v) res = (raw > 0) ? 31 : -32;
`endif
            end
            3'd1: begin
               raw = a - b;
               c   = ua < ub;
               v   = (raw > 31) || (raw < -32);
               res = wrap6(raw);
`ifdef EXE_SAT_EN
               if (v) res = (raw > 0) ? 31 : -32;
`endif
            end
            3'd2: begin
               u = ua;
               if (b > 0) begin
                  for (int k = 0; k < b; k++) begin
                     c = ((u >> 5) & 1) != 0;
                     u = (u << 1) & 63;
                  end
               end else if (b < 0) begin
                  for (int k = 0; k < -b; k++) begin
                     c = (u & 1) != 0;
                     u = (u >> 1) | (u & 32);
                  end
               end
               res = sx(6'(u));
            end
            3'd3: res = wrap6(ua & ub);
            3'd4: res = wrap6(ua | ub);
            3'd5: res = wrap6(ua ^ ub);
            3'd6: res = wrap6(~a);
            default: res = a;
         endcase
      end
      if (r) begin
         exp_data = '0;
         exp_flag = '0;
         for (int i = 0; i < 16; i++) m_regs[i] = 0;
      end else begin
         exp_data = 6'(res);
         exp_flag = {res == 0, res < 0, c, v};
         if (rd != 0) m_regs[rd] = res;
      end
   endtask

   // Drive one instruction, update the model, then step to just after the edge.
   task automatic apply(input bit r, input bit im, input logic [2:0] op,
                        input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rd,
                        input logic [5:0] d, input logic [5:0] d2);
      rsn   = r;
      imm   = im;
      oper  = op;
      reg0  = ra;
      reg1  = rb;
      reg2  = rd;
      data  = d;
      data2 = d2;
      model(r, im, op, ra, rb, rd, d, d2);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      apply(1, 0, 3'd0, 0, 0, 0, 6'd0, 6'd0);
      apply(1, 1, 3'd0, 0, 0, 5, 6'd9, 6'd0);
      n_vec++;
      if ({o_data, o_flag} !== 10'd0) begin
         n_miss++;
         $display("FAIL reset_out got data=%0d flag=%b want data=0 flag=0000", o_data, o_flag);
      end
      for (int i = 1; i < 16; i++) begin
         apply(0, 0, 3'd7, 4'(i), 0, 0, 6'd0, 6'd17);
         n_vec++;
         if ({o_data, o_flag} !== {6'd0, 4'b1000}) begin
            n_miss++;
            $display("FAIL reset_reg R%0d got data=%0d flag=%b want data=0 flag=1000", i, o_data, o_flag);
         end
      end
   endtask

   task automatic test_sequence;
      step_t seq [14];
      seq[0]  = '{1'b1, 3'd0, 4'd0,  4'd0, 4'd1,  6'd2,  6'd2,        4'b0000};
      seq[1]  = '{1'b1, 3'd0, 4'd0,  4'd0, 4'd2,  6'd5,  6'd5,        4'b0000};
      seq[2]  = '{1'b0, 3'd0, 4'd1,  4'd2, 4'd3,  6'd0,  6'd7,        4'b0000};
      seq[3]  = '{1'b0, 3'd1, 4'd2,  4'd3, 4'd4,  6'd0,  6'b111110,   4'b0110};
      seq[4]  = '{1'b0, 3'd2, 4'd2,  4'd1, 4'd5,  6'd0,  6'd20,       4'b0000};
      seq[5]  = '{1'b0, 3'd2, 4'd5,  4'd4, 4'd6,  6'd0,  6'd5,        4'b0000};
      seq[6]  = '{1'b0, 3'd3, 4'd5,  4'd3, 4'd7,  6'd0,  6'd4,        4'b0000};
      seq[7]  = '{1'b0, 3'd4, 4'd5,  4'd1, 4'd8,  6'd0,  6'd22,       4'b0000};
      seq[8]  = '{1'b0, 3'd5, 4'd7,  4'd8, 4'd9,  6'd0,  6'd18,       4'b0000};
      seq[9]  = '{1'b1, 3'd0, 4'd0,  4'd0, 4'd10, 6'd31, 6'd31,       4'b0000};
      seq[10] = '{1'b1, 3'd0, 4'd0,  4'd0, 4'd11, 6'd1,  6'd1,        4'b0000};
`ifdef EXE_SAT_EN
      seq[11] = '{1'b0, 3'd0, 4'd10, 4'd11, 4'd12, 6'd0, 6'd31,       4'b0001};
`else
      seq[11] = '{1'b0, 3'd0, 4'd10, 4'd11, 4'd12, 6'd0, 6'b100000,   4'b0101};
`endif
      seq[12] = '{1'b1, 3'd0, 4'd0,  4'd0, 4'd13, 6'd0,  6'd0,        4'b1000};
      seq[13] = '{1'b0, 3'd1, 4'd13, 4'd13, 4'd14, 6'd0, 6'd0,        4'b1000};
      for (int i = 0; i < 14; i++) begin
         apply(0, seq[i].im, seq[i].op, seq[i].ra, seq[i].rb, seq[i].rd, seq[i].d, 6'd0);
         n_vec++;
         if ({o_data, o_flag} !== {seq[i].ed, seq[i].ef}) begin
            n_miss++;
            $display("FAIL seq_step%0d got data=%0d flag=%b want data=%0d flag=%b",
                     i, o_data, o_flag, seq[i].ed, seq[i].ef);
         end
      end
   endtask

   task automatic test_r0;
      // Immediate aimed at R0 still appears on the output but is not stored.
      apply(0, 1, 3'd0, 0, 0, 0, 6'd9, 6'd13);
      n_vec++;
      if ({o_data, o_flag} !== {6'd9, 4'b0000}) begin
         n_miss++;
         $display("FAIL r0_write got data=%0d flag=%b want data=9 flag=0000", o_data, o_flag);
      end
      apply(0, 0, 3'd7, 0, 0, 1, 6'd0, 6'b111011);
      n_vec++;
      if ({o_data, o_flag} !== {6'b111011, 4'b0100}) begin
         n_miss++;
         $display("FAIL r0_read got data=%0d flag=%b want data=59 flag=0100", o_data, o_flag);
      end
      apply(0, 0, 3'd0, 0, 1, 2, 6'd0, 6'd0);
      n_vec++;
      if ({o_data, o_flag} !== {6'b111011, 4'b0100}) begin
         n_miss++;
         $display("FAIL r0_add got data=%0d flag=%b want data=59 flag=0100", o_data, o_flag);
      end
   endtask

   task automatic test_random;
      bit         r_im;
      logic [2:0] r_op;
      logic [3:0] r_a, r_b, r_d;
      logic [5:0] r_dat, r_d2;
      for (int i = 0; i < 400; i++) begin
         r_im  = ($urandom_range(0, 9) < 3);
         r_op  = 3'($urandom);
         r_a   = 4'($urandom);
         r_b   = 4'($urandom);
         r_d   = 4'($urandom);
         r_dat = 6'($urandom);
         r_d2  = 6'($urandom);
         apply(0, r_im, r_op, r_a, r_b, r_d, r_dat, r_d2);
         n_vec++;
         if ({o_data, o_flag} !== {exp_data, exp_flag}) begin
            n_miss++;
            $display("FAIL rand%0d imm=%0b op=%0d a=R%0d b=R%0d d=R%0d got data=%0d flag=%b want data=%0d flag=%b",
                     i, r_im, r_op, r_a, r_b, r_d, o_data, o_flag, exp_data, exp_flag);
         end
      end
   endtask

   task automatic test_reset_priority;
      apply(0, 1, 3'd0, 0, 0, 3, 6'd21, 6'd0);
      apply(0, 0, 3'd0, 3, 3, 4, 6'd0, 6'd0);
      // Reset together with a write: the write must lose.
      apply(1, 1, 3'd0, 0, 0, 3, 6'd7, 6'd0);
      n_vec++;
      if ({o_data, o_flag} !== 10'd0) begin
         n_miss++;
         $display("FAIL rst_prio_out got data=%0d flag=%b want data=0 flag=0000", o_data, o_flag);
      end
      for (int i = 1; i < 16; i++) begin
         apply(0, 0, 3'd7, 4'(i), 0, 0, 6'd0, 6'd5);
         n_vec++;
         if ({o_data, o_flag} !== {exp_data, exp_flag}) begin
            n_miss++;
            $display("FAIL rst_prio_reg R%0d got data=%0d flag=%b want data=%0d flag=%b",
                     i, o_data, o_flag, exp_data, exp_flag);
         end
      end
   endtask

   initial begin
      rsn   = 1'b1;
      imm   = 1'b0;
      oper  = 3'd0;
      reg0  = '0;
      reg1  = '0;
      reg2  = '0;
      data  = '0;
      data2 = '0;
      for (int i = 0; i < 16; i++) m_regs[i] = 0;
      test_reset();
      test_sequence();
      test_r0();
      test_random();
      test_reset_priority();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
